updown_mod_counter: RTL and testbench
=====================================

# updown_mod_counter

Parametrised up/down counter with programmable modulus, step size, wrap or saturate mode, terminal-count pulse and sticky overflow/underflow flags. It generalises the plain up/down counter into a general-purpose event/timebase counter for control and timing logic. One instance per counted quantity; all outputs are registered, and `at_max`/`at_zero` are decoded from the count register.

## Interface
- `WIDTH`, default 8: count, limit and load-value width.
- `STEP_W`, default 4: width of the step input.
- `PSC_W`, default 8: prescaler width. Used only when the prescaler is compiled in.
- `clk` in 1: clock, rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-low.
- `en` in 1: count enable. Low freezes the count and prescaler. Does not block `set` or `clr_flags`.
- `set` in 1: synchronous load of `set_value`.
- `set_value` in WIDTH: load value.
- `up` in 1: count-up request.
- `down` in 1: count-down request.
- `mode` in 1: 0 = wrap (modulo `max_value`+1), 1 = saturate.
- `max_value` in WIDTH: inclusive upper limit. Legal range is 0..`max_value`.
- `step` in STEP_W: increment/decrement amount.
- `psc_div` in PSC_W: prescaler divide value. Present only with the prescaler compiled in.
- `clr_flags` in 1: clears `ovf` and `unf`.
- `count` out WIDTH: current count.
- `tc` out 1: one-cycle terminal-count pulse.
- `ovf` out 1: sticky overflow flag.
- `unf` out 1: sticky underflow flag.
- `at_max` out 1: `count` == `max_value`.
- `at_zero` out 1: `count` == 0.

## Operation
- **Reset** (`reset` low, asynchronous): `count`=0, `tc`=0, `ovf`=0, `unf`=0, prescaler=0. `at_zero`=1. `at_max`=1 only if `max_value`=0.
- **Priority per edge:** `set` > (`up`&`down`: hold) > `up` > `down` > hold.
- **Step condition:** a step occurs only when `en`=1 and a prescaler tick is present. Without the prescaler compiled in, every cycle is a tick.
- **Load:** `set` loads min(`set_value`, `max_value`) and clears the prescaler. No `tc`, no flag change.
- **Effective step:** S = min(`step`, `max_value`+1). Arithmetic uses WIDTH+1 bits internally.
- **S = 0:** no movement, no `tc`, no flag change.
- **Up step:**
  - If `count`+S ≤ `max_value`: `count` += S.
  - Otherwise, wrap mode: `count` = `count`+S−(`max_value`+1). Saturate mode: `count` = `max_value`.
  - Either overflow case sets `ovf` and pulses `tc`.
- **Down step:**
  - If S ≤ `count`: `count` −= S.
  - Otherwise, wrap mode: `count` = `count`+(`max_value`+1)−S. Saturate mode: `count` = 0.
  - Either underflow case sets `unf` and pulses `tc`.
- **Saturation:** in saturate mode, a request at the limit (up at `max_value`, down at 0) still sets the flag and pulses `tc` every stepping cycle.
- **Out-of-range count** (`max_value` lowered below `count` at runtime): the next step of either direction forces `count` = `max_value` in saturate mode or 0 in wrap mode, sets `ovf`, and pulses `tc`.
- **Flags:** `ovf` and `unf` stay set until `clr_flags`. A set event in the same cycle as `clr_flags` wins, so the flag stays 1.
- **Mid-operation reset:** clears all state immediately, with no pending pulse.

## Timing
- `count`, `tc`, `ovf` and `unf` update on the rising `clk` edge following the qualifying inputs: one-cycle latency.
- `tc` is high for exactly the one cycle in which the post-event `count` is presented.
- `at_max` and `at_zero` follow `count` combinationally, with no additional latency.
- Inputs are sampled every edge. No handshake.
- `max_value`, `mode` and `step` may change on any cycle and take effect on that edge.

## Configuration
- Macro: `UPDOWN_MOD_COUNTER_PRESCALER_EN`.
- **Defined:**
  - `psc_div` port exists, with a PSC_W-bit prescaler counter running while `en`=1.
  - A tick occurs in the cycle the prescaler equals `psc_div`; the prescaler returns to 0 on that edge, otherwise it increments.
  - `psc_div`=0 ticks every enabled cycle.
  - A step occurs once per `psc_div`+1 enabled cycles.
- **Undefined:** no `psc_div` port and no prescaler logic. Every enabled cycle is a tick.

## Test plan
- Reset mid-count: `count`=37, pull `reset` low between edges → `count`=0, `at_zero`=1 immediately, all flags 0.
- Wrap up: `max_value`=9, `mode`=0, `step`=3, start 0, `up` held → sequence 3, 6, 9, 2. `tc` and `ovf` are set in the cycle `count`=2.
- Saturate down: `max_value`=200, `mode`=1, `step`=5, `count`=7 → 2, then 0 with `unf`=1 and `tc`=1, then 0 with `tc`=1 again.
- Priority: `set`=1, `up`=1, `set_value`=250, `max_value`=100 → `count`=100, no `tc`. Then `up`=`down`=1 → holds at 100.
- Flag race: overflow event in the same cycle as `clr_flags` → `ovf`=1. Next cycle `clr_flags` alone → `ovf`=0.
- Prescaler (macro defined): `psc_div`=3, `step`=1, `up` held → `count` increments every 4th enabled cycle. Dropping `en` for 2 cycles delays the next step by 2.

Source files
------------

// File: rtl/updown_mod_counter_if.sv
// rtl/updown_mod_counter_if.sv - control/status bundle for updown_mod_counter
// psc_div exists only when UPDOWN_MOD_COUNTER_PRESCALER_EN is defined.
interface updown_mod_counter_if #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4,
    parameter int PSC_W  = 8
);
    logic              en;
    logic              set;
    logic [WIDTH-1:0]  set_value;
    logic              up;
    logic              down;
    logic              mode;
    logic [WIDTH-1:0]  max_value;
    logic [STEP_W-1:0] step;
`ifdef UPDOWN_MOD_COUNTER_PRESCALER_EN
    logic [PSC_W-1:0]  psc_div;
`endif
    logic              clr_flags;
    logic [WIDTH-1:0]  count;
    logic              tc;
    logic              ovf;
    logic              unf;
    logic              at_max;
    logic              at_zero;

    if (WIDTH < 1 || STEP_W < 1 || PSC_W < 1) begin : g_param_check
        $error("updown_mod_counter_if: widths must be at least 1");
    end

    modport master (
`ifdef UPDOWN_MOD_COUNTER_PRESCALER_EN
        output psc_div,
`endif
        output en, set, set_value, up, down, mode, max_value, step, clr_flags,
        input  count, tc, ovf, unf, at_max, at_zero
    );

    modport slave (
`ifdef UPDOWN_MOD_COUNTER_PRESCALER_EN
        input  psc_div,
`endif
        input  en, set, set_value, up, down, mode, max_value, step, clr_flags,
        output count, tc, ovf, unf, at_max, at_zero
    );
endinterface

// File: rtl/updown_mod_counter.sv
// rtl/updown_mod_counter.sv - up/down counter with modulus, step, wrap/saturate and sticky flags
// Optional prescaler compiled in with UPDOWN_MOD_COUNTER_PRESCALER_EN.
module updown_mod_counter #(
    parameter int WIDTH  = 8,
    parameter int STEP_W = 4,
    parameter int PSC_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    updown_mod_counter_if.slave bus
);
    // CW holds both the raw step and max_value+1 so the step clamp never truncates
    localparam int CW = ((WIDTH + 1) > STEP_W) ? (WIDTH + 2) : (STEP_W + 1);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    if (WIDTH < 1 || STEP_W < 1 || PSC_W < 1) begin : g_param_check
        $error("updown_mod_counter: widths must be at least 1");
    end

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;
    logic             r_unf;

    logic             w_tick;
    logic [CW-1:0]    w_step_c;
    logic [CW-1:0]    w_maxp1_c;
    logic [WIDTH:0]   w_s;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_cnt_x;
    logic [WIDTH:0]   w_max_x;
    logic [WIDTH-1:0] w_up_wrap;
    logic [WIDTH-1:0] w_dn_norm;
    logic [WIDTH-1:0] w_dn_wrap;
    logic [WIDTH-1:0] w_load;
    logic             w_oor;
    logic             w_step_go;
    logic [WIDTH-1:0] w_nxt_count;
    logic             w_evt_ovf;
    logic             w_evt_unf;

`ifdef UPDOWN_MOD_COUNTER_PRESCALER_EN
    logic [PSC_W-1:0] r_psc;

    assign w_tick = (r_psc == bus.psc_div);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_psc <= '0;
        end else if (bus.set) begin
            r_psc <= '0;
        end else if (bus.en) begin
            r_psc <= w_tick ? '0 : r_psc + PSC_W'(1);
        end
    end
`else
    assign w_tick = 1'b1;
`endif

    assign w_step_c  = CW'(bus.step);
    assign w_maxp1_c = CW'(bus.max_value) + CW'(1);
    assign w_s       = (w_step_c < w_maxp1_c) ? w_step_c[WIDTH:0] : w_maxp1_c[WIDTH:0];

    assign w_cnt_x   = {1'b0, r_count};
    assign w_max_x   = {1'b0, bus.max_value};
    assign w_sum     = w_cnt_x + w_s;
    assign w_oor     = r_count > bus.max_value;
    assign w_load    = (bus.set_value < bus.max_value) ? bus.set_value : bus.max_value;

    // Wrapped results always land in 0..max_value, so modulo-2^WIDTH arithmetic is exact
    assign w_up_wrap = r_count + w_s[WIDTH-1:0] - bus.max_value - ONE;
    assign w_dn_norm = r_count - w_s[WIDTH-1:0];
    assign w_dn_wrap = r_count + bus.max_value + ONE - w_s[WIDTH-1:0];

    assign w_step_go = bus.en && w_tick && (bus.up != bus.down) && (w_s != '0);

    always_comb begin
        w_nxt_count = r_count;
        w_evt_ovf   = 1'b0;
        w_evt_unf   = 1'b0;
        if (bus.set) begin
            w_nxt_count = w_load;
        end else if (w_step_go) begin
            if (w_oor) begin
                w_nxt_count = bus.mode ? bus.max_value : '0;
                w_evt_ovf   = 1'b1;
            end else if (bus.up) begin
                if (w_sum <= w_max_x) begin
                    w_nxt_count = w_sum[WIDTH-1:0];
                end else begin
                    w_nxt_count = bus.mode ? bus.max_value : w_up_wrap;
                    w_evt_ovf   = 1'b1;
                end
            end else begin
                if (w_s <= w_cnt_x) begin
                    w_nxt_count = w_dn_norm;
                end else begin
                    w_nxt_count = bus.mode ? '0 : w_dn_wrap;
                    w_evt_unf   = 1'b1;
                end
            end
        end
    end

    // A flag event in the same cycle as clr_flags keeps the flag set
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else begin
            r_count <= w_nxt_count;
            r_tc    <= w_evt_ovf | w_evt_unf;
            r_ovf   <= w_evt_ovf | (r_ovf & ~bus.clr_flags);
            r_unf   <= w_evt_unf | (r_unf & ~bus.clr_flags);
        end
    end

    assign bus.count   = r_count;
    assign bus.tc      = r_tc;
    assign bus.ovf     = r_ovf;
    assign bus.unf     = r_unf;
    assign bus.at_max  = (r_count == bus.max_value);
    assign bus.at_zero = (r_count == '0);
endmodule

// File: tb/tb_updown_mod_counter.sv
// tb/tb_updown_mod_counter.sv - directed bench with integer reference model for updown_mod_counter
module tb_updown_mod_counter;
    localparam int WIDTH  = 8;
    localparam int STEP_W = 4;
    localparam int PSC_W  = 8;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    int   n_chk  = 0;
    int   n_fail = 0;
    bit   cmp_on = 1'b0;

    always #5 clk = ~clk;

    updown_mod_counter_if #(.WIDTH(WIDTH), .STEP_W(STEP_W), .PSC_W(PSC_W)) bus ();

    updown_mod_counter #(.WIDTH(WIDTH), .STEP_W(STEP_W), .PSC_W(PSC_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int m_count;
    bit m_tc, m_ovf, m_unf;
    int m_psc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic void model_next(input int c, input int psc, output int nc,
                                       output bit eo, output bit eu, output int npsc);
        int mx, s, stp;
        bit tick;
        mx  = int'(bus.max_value);
        stp = int'(bus.step);
        s   = (stp < mx + 1) ? stp : mx + 1;
`ifdef UPDOWN_MOD_COUNTER_PRESCALER_EN
        tick = (psc == int'(bus.psc_div));
`else
        tick = 1'b1;
`endif
        nc = c; eo = 0; eu = 0; npsc = psc;
        if (bus.set) begin
            nc   = (int'(bus.set_value) < mx) ? int'(bus.set_value) : mx;
            npsc = 0;
        end else begin
            if (bus.en) npsc = tick ? 0 : psc + 1;
            if (bus.en && tick && (bus.up != bus.down) && s > 0) begin
                if (c > mx) begin
                    nc = bus.mode ? mx : 0;
                    eo = 1;
                end else if (bus.up) begin
                    if (c + s <= mx) nc = c + s;
                    else begin
                        eo = 1;
                        nc = bus.mode ? mx : c + s - (mx + 1);
                    end
                end else begin
                    if (s <= c) nc = c - s;
                    else begin
                        eu = 1;
                        nc = bus.mode ? 0 : c + mx + 1 - s;
                    end
                end
            end
        end
    endfunction

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_count <= 0;
            m_tc    <= 0;
            m_ovf   <= 0;
            m_unf   <= 0;
            m_psc   <= 0;
        end else begin : upd
            int nc, npsc;
            bit eo, eu;
            model_next(m_count, m_psc, nc, eo, eu, npsc);
            m_count <= nc;
            m_tc    <= eo | eu;
            m_ovf   <= eo | (m_ovf & !bus.clr_flags);
            m_unf   <= eu | (m_unf & !bus.clr_flags);
            m_psc   <= npsc;
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            chk("model_count",   32'(bus.count),   32'(m_count));
            chk("model_tc",      32'(bus.tc),      32'(m_tc));
            chk("model_ovf",     32'(bus.ovf),     32'(m_ovf));
            chk("model_unf",     32'(bus.unf),     32'(m_unf));
            chk("model_at_max",  32'(bus.at_max),  32'(m_count == int'(bus.max_value)));
            chk("model_at_zero", 32'(bus.at_zero), 32'(m_count == 0));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_state(input string name, input int cnt, input bit tc,
                                input bit ovf, input bit unf);
        chk({name, "_count"}, 32'(bus.count), 32'(cnt));
        chk({name, "_tc"},    32'(bus.tc),    32'(tc));
        chk({name, "_ovf"},   32'(bus.ovf),   32'(ovf));
        chk({name, "_unf"},   32'(bus.unf),   32'(unf));
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        bus.en = 0; bus.set = 0; bus.set_value = '0; bus.up = 0; bus.down = 0;
        bus.mode = 0; bus.max_value = '0; bus.step = '0; bus.clr_flags = 0;
`ifdef UPDOWN_MOD_COUNTER_PRESCALER_EN
        bus.psc_div = '0;
`endif
        #12;
        cmp_on = 1;
        expect_state("reset", 0, 0, 0, 0);
        chk("reset_at_zero", 32'(bus.at_zero), 1);
        chk("reset_at_max_m0", 32'(bus.at_max), 1);
        bus.max_value = 8'd5;
        #1 chk("reset_at_max_m5", 32'(bus.at_max), 0);
        @(negedge clk) reset = 1;
        @(posedge clk); #1;

        // wrap up: max 9, step 3
        bus.en = 1; bus.max_value = 9; bus.mode = 0; bus.step = 3; bus.up = 1;
        cyc(1); expect_state("wrap1", 3, 0, 0, 0);
        cyc(1); expect_state("wrap2", 6, 0, 0, 0);
        cyc(1); expect_state("wrap3", 9, 0, 0, 0);
        chk("wrap3_at_max", 32'(bus.at_max), 1);
        cyc(1); expect_state("wrap4", 2, 1, 1, 0);
        bus.up = 0;
        cyc(1); expect_state("wrap_idle", 2, 0, 1, 0);
        bus.clr_flags = 1;
        cyc(1); expect_state("wrap_clr", 2, 0, 0, 0);
        bus.clr_flags = 0;

        // saturate down: max 200, step 5, from 7
        bus.max_value = 200; bus.mode = 1; bus.step = 5; bus.set = 1; bus.set_value = 7;
        cyc(1); expect_state("sat_load", 7, 0, 0, 0);
        bus.set = 0; bus.down = 1;
        cyc(1); expect_state("sat1", 2, 0, 0, 0);
        cyc(1); expect_state("sat2", 0, 1, 0, 1);
        chk("sat2_at_zero", 32'(bus.at_zero), 1);
        cyc(1); expect_state("sat3", 0, 1, 0, 1);
        bus.down = 0;

        // priority: set beats up, load clamps to max; up&down holds
        bus.set = 1; bus.up = 1; bus.set_value = 250; bus.max_value = 100;
        cyc(1); expect_state("prio_set", 100, 0, 0, 1);
        bus.set = 0; bus.down = 1;
        cyc(1); expect_state("prio_hold", 100, 0, 0, 1);

        // flag race: ovf event with clr_flags keeps ovf; unf clears
        bus.down = 0; bus.mode = 0; bus.step = 1; bus.clr_flags = 1;
        cyc(1); expect_state("race", 0, 1, 1, 0);
        bus.up = 0;
        cyc(1); expect_state("race_clr", 0, 0, 0, 0);
        bus.clr_flags = 0;

        // out-of-range count after max_value lowered
        bus.set = 1; bus.set_value = 50;
        cyc(1); expect_state("oor_load", 50, 0, 0, 0);
        bus.set = 0; bus.max_value = 20; bus.mode = 1; bus.down = 1;
        cyc(1); expect_state("oor_sat", 20, 1, 1, 0);
        bus.down = 0; bus.clr_flags = 1; bus.set = 1; bus.set_value = 50; bus.max_value = 100;
        cyc(1); expect_state("oor_reload", 50, 0, 0, 0);
        bus.clr_flags = 0; bus.set = 0; bus.max_value = 20; bus.mode = 0; bus.up = 1;
        cyc(1); expect_state("oor_wrap", 0, 1, 1, 0);
        bus.up = 0;

        // step clamp to max+1, and step 0
        bus.max_value = 2; bus.step = 15; bus.set = 1; bus.set_value = 1;
        cyc(1); expect_state("clamp_load", 1, 0, 1, 0);
        bus.set = 0; bus.up = 1;
        cyc(1); expect_state("clamp_up", 1, 1, 1, 0);
        bus.up = 0; bus.down = 1;
        cyc(1); expect_state("clamp_dn", 1, 1, 1, 1);
        bus.step = 0;
        cyc(1); expect_state("step0", 1, 0, 1, 1);

        // en low freezes
        bus.step = 1; bus.down = 0; bus.up = 1; bus.en = 0;
        cyc(2); expect_state("en_off", 1, 0, 1, 1);
        bus.en = 1;
        cyc(1); expect_state("en_on", 2, 0, 1, 1);
        chk("en_on_at_max", 32'(bus.at_max), 1);

        // reset mid-count
        bus.up = 0; bus.max_value = 100; bus.set = 1; bus.set_value = 37;
        cyc(1); expect_state("pre_rst", 37, 0, 1, 1);
        bus.set = 0;
        #3 reset = 0;
        #1 expect_state("mid_rst", 0, 0, 0, 0);
        chk("mid_rst_at_zero", 32'(bus.at_zero), 1);
        @(negedge clk) reset = 1;
        @(posedge clk); #1;

`ifdef UPDOWN_MOD_COUNTER_PRESCALER_EN
        bus.en = 1; bus.max_value = 100; bus.mode = 0; bus.step = 1; bus.psc_div = 3;
        bus.set = 1; bus.set_value = 0;
        cyc(1);
        bus.set = 0; bus.up = 1;
        cyc(3); expect_state("psc_wait", 0, 0, 0, 0);
        cyc(1); expect_state("psc_tick1", 1, 0, 0, 0);
        bus.en = 0;
        cyc(2); expect_state("psc_frozen", 1, 0, 0, 0);
        bus.en = 1;
        cyc(3); expect_state("psc_delayed", 1, 0, 0, 0);
        cyc(1); expect_state("psc_tick2", 2, 0, 0, 0);
        bus.psc_div = 0;
        cyc(1); expect_state("psc_div0_a", 3, 0, 0, 0);
        cyc(1); expect_state("psc_div0_b", 4, 0, 0, 0);
        bus.up = 0;
`endif

        cyc(2);
        cmp_on = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
